// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Signal bundle between the pipeline datapath and pipe_ctrl.
//               master = pipeline side (drives hazard status, receives
//               stall/bubble/flush controls); slave = pipe_ctrl.
//               PIPE_CTRL_PERF_EN adds the two performance counter outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if;
    logic        id_reg1_read;
    logic [3:0]  id_reg1_addr;
    logic        id_reg2_read;
    logic [3:0]  id_reg2_addr;
    logic        ex_is_load;
    logic        ex_wreg;
    logic [3:0]  ex_wd;
    logic        stallreq_ex;
    logic        ex_done;
    logic        flush_req;
    logic [4:0]  stall;
    logic        bubble_idex;
    logic        bubble_exmem;
    logic        flush;
    logic        stall_timeout;
`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] perf_stall_cyc;
    logic [15:0] perf_flush_cnt;
`endif

    modport master (
        output id_reg1_read, id_reg1_addr, id_reg2_read, id_reg2_addr,
        output ex_is_load, ex_wreg, ex_wd, stallreq_ex, ex_done, flush_req,
        input  stall, bubble_idex, bubble_exmem, flush, stall_timeout
`ifdef PIPE_CTRL_PERF_EN
        , input perf_stall_cyc, perf_flush_cnt
`endif
    );

    modport slave (
        input  id_reg1_read, id_reg1_addr, id_reg2_read, id_reg2_addr,
        input  ex_is_load, ex_wreg, ex_wd, stallreq_ex, ex_done, flush_req,
        output stall, bubble_idex, bubble_exmem, flush, stall_timeout
`ifdef PIPE_CTRL_PERF_EN
        , output perf_stall_cyc, perf_flush_cnt
`endif
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline sequencing controller for the 16-bit core.
//               Detects load-use hazards, holds the front of the pipe for
//               multi-cycle EX operations (with a stall watchdog), and
//               sequences branch flushes, including flushes requested while
//               a multi-cycle op is still running.
//               Optional macro PIPE_CTRL_PERF_EN adds saturating stall-cycle
//               and flush-cycle counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int MAX_STALL = 64,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_EX_WAIT = 2'd1,
        S_FLUSH   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_wdog_max  = CNT_W'(MAX_STALL);
    localparam logic [4:0]       c_stall_lu  = 5'b00011;
    localparam logic [4:0]       c_stall_ex  = 5'b00111;

    state_t           r_state;
    logic             r_pending_flush;
    logic [CNT_W-1:0] r_wdog;
    logic             r_timeout;

    logic             w_load_use;
    logic             w_wdog_hit;
    logic             w_go_flush;
    logic [4:0]       w_stall;
    logic             w_bubble_idex;
    logic             w_bubble_exmem;
    logic             w_flush;

    // Register 0 is an ordinary register here, so no zero-address exemption.
    assign w_load_use = bus.ex_is_load & bus.ex_wreg &
                        ((bus.id_reg1_read & (bus.id_reg1_addr == bus.ex_wd)) |
                         (bus.id_reg2_read & (bus.id_reg2_addr == bus.ex_wd)));

    // Watchdog expiry only counts when the op has not finished this cycle.
    assign w_wdog_hit = ~rst & (r_state == S_EX_WAIT) & ~bus.ex_done &
                        (r_wdog == c_wdog_max);

    // A flush seen on the same cycle the wait ends is treated as pending.
    assign w_go_flush = r_pending_flush | bus.flush_req;

    // Mealy control decode from current state and hazard inputs.
    always_comb begin
        w_stall        = 5'b00000;
        w_bubble_idex  = 1'b0;
        w_bubble_exmem = 1'b0;
        w_flush        = 1'b0;
        if (!rst) begin
            case (r_state)
                S_RUN: begin
                    if (bus.flush_req) begin
                        w_stall = 5'b00000;
                    end else if (bus.stallreq_ex) begin
                        w_stall        = c_stall_ex;
                        w_bubble_exmem = 1'b1;
                    end else if (w_load_use) begin
                        w_stall       = c_stall_lu;
                        w_bubble_idex = 1'b1;
                    end
                end
                S_EX_WAIT: begin
                    if (!bus.ex_done && !w_wdog_hit) begin
                        w_stall        = c_stall_ex;
                        w_bubble_exmem = 1'b1;
                    end
                end
                S_FLUSH: begin
                    w_flush = 1'b1;
                end
                default: begin
                    w_stall = 5'b00000;
                end
            endcase
        end
    end

    // Sequencer: state, deferred flush, watchdog count and sticky timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_RUN;
            r_pending_flush <= 1'b0;
            r_wdog          <= '0;
            r_timeout       <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (bus.flush_req) begin
                        r_state <= S_FLUSH;
                    end else if (bus.stallreq_ex) begin
                        r_state <= S_EX_WAIT;
                        r_wdog  <= CNT_W'(1);
                    end
                end
                S_EX_WAIT: begin
                    if (bus.ex_done || w_wdog_hit) begin
                        r_state         <= w_go_flush ? S_FLUSH : S_RUN;
                        r_pending_flush <= 1'b0;
                        if (w_wdog_hit) begin
                            r_timeout <= 1'b1;
                        end
                    end else begin
                        r_wdog <= r_wdog + CNT_W'(1);
                        if (bus.flush_req) begin
                            r_pending_flush <= 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    r_pending_flush <= 1'b0;
                    r_state         <= bus.flush_req ? S_FLUSH : S_RUN;
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

    // stall[4:3] belong to a future MEM-wait source and stay low.
    assign bus.stall         = w_stall;
    assign bus.bubble_idex   = w_bubble_idex;
    assign bus.bubble_exmem  = w_bubble_exmem;
    assign bus.flush         = w_flush;
    assign bus.stall_timeout = ~rst & (r_timeout | w_wdog_hit);

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] r_perf_stall_cyc;
    logic [15:0] r_perf_flush_cnt;

    // Saturating counts of stalled cycles and flush cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall_cyc <= 16'd0;
            r_perf_flush_cnt <= 16'd0;
        end else begin
            if ((w_stall != 5'b00000) && (r_perf_stall_cyc != 16'hFFFF)) begin
                r_perf_stall_cyc <= r_perf_stall_cyc + 16'd1;
            end
            if (w_flush && (r_perf_flush_cnt != 16'hFFFF)) begin
                r_perf_flush_cnt <= r_perf_flush_cnt + 16'd1;
            end
        end
    end

    assign bus.perf_stall_cyc = rst ? 16'd0 : r_perf_stall_cyc;
    assign bus.perf_flush_cnt = rst ? 16'd0 : r_perf_flush_cnt;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl. Two instances (watchdog
//               limits 64 and 4) share one stimulus stream of directed hazard
//               scenarios followed by random traffic, each compared against a
//               cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       r1_rd, r2_rd, is_load, wreg, sreq, done, freq;
    logic [3:0] r1_a, r2_a, wd;

    pipe_ctrl_if bus0 ();
    pipe_ctrl_if bus1 ();

    assign bus0.id_reg1_read = r1_rd;  assign bus1.id_reg1_read = r1_rd;
    assign bus0.id_reg1_addr = r1_a;   assign bus1.id_reg1_addr = r1_a;
    assign bus0.id_reg2_read = r2_rd;  assign bus1.id_reg2_read = r2_rd;
    assign bus0.id_reg2_addr = r2_a;   assign bus1.id_reg2_addr = r2_a;
    assign bus0.ex_is_load   = is_load; assign bus1.ex_is_load  = is_load;
    assign bus0.ex_wreg      = wreg;   assign bus1.ex_wreg      = wreg;
    assign bus0.ex_wd        = wd;     assign bus1.ex_wd        = wd;
    assign bus0.stallreq_ex  = sreq;   assign bus1.stallreq_ex  = sreq;
    assign bus0.ex_done      = done;   assign bus1.ex_done      = done;
    assign bus0.flush_req    = freq;   assign bus1.flush_req    = freq;

    pipe_ctrl #(.MAX_STALL(64), .CNT_W(8)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    pipe_ctrl #(.MAX_STALL(4),  .CNT_W(3)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    logic [4:0] o_stall [2];
    logic       o_bi [2], o_be [2], o_fl [2], o_to [2];
    assign o_stall[0] = bus0.stall;         assign o_stall[1] = bus1.stall;
    assign o_bi[0]    = bus0.bubble_idex;   assign o_bi[1]    = bus1.bubble_idex;
    assign o_be[0]    = bus0.bubble_exmem;  assign o_be[1]    = bus1.bubble_exmem;
    assign o_fl[0]    = bus0.flush;         assign o_fl[1]    = bus1.flush;
    assign o_to[0]    = bus0.stall_timeout; assign o_to[1]    = bus1.stall_timeout;
`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] o_pst [2], o_pfl [2];
    assign o_pst[0] = bus0.perf_stall_cyc;  assign o_pst[1] = bus1.perf_stall_cyc;
    assign o_pfl[0] = bus0.perf_flush_cnt;  assign o_pfl[1] = bus1.perf_flush_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Model state: "waiting" = multi-cycle op outstanding, "elapsed" = cycles
    // since the op started, "flush_due" = flush happens this coming cycle.
    bit          m_waiting   [2];
    int          m_elapsed   [2];
    bit          m_pending   [2];
    bit          m_flush_due [2];
    bit          m_tout      [2];
    int unsigned m_pstall    [2];
    int unsigned m_pflush    [2];

    function automatic int max_stall(input int k);
        return (k == 0) ? 64 : 4;
    endfunction

    task automatic check_val(input string tag, input int k,
                             input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", tag, k, cyc, got, exp);
        end
    endtask

    task automatic set_idle();
        r1_rd = 0; r1_a = 0; r2_rd = 0; r2_a = 0;
        is_load = 0; wreg = 0; wd = 0; sreq = 0; done = 0; freq = 0;
    endtask

    task automatic set_random();
        r1_rd   = ($urandom_range(0, 99) < 60);
        r2_rd   = ($urandom_range(0, 99) < 60);
        r1_a    = 4'($urandom_range(0, 3));
        r2_a    = 4'($urandom_range(0, 3));
        wd      = 4'($urandom_range(0, 3));
        is_load = ($urandom_range(0, 99) < 50);
        wreg    = ($urandom_range(0, 99) < 70);
        sreq    = ($urandom_range(0, 99) < 15);
        done    = ($urandom_range(0, 99) < 20);
        freq    = ($urandom_range(0, 99) < 10);
        rst     = ($urandom_range(0, 199) == 0);
    endtask

    // One clock: evaluate the model, compare at the falling edge, advance.
    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            logic [4:0] e_stall;
            bit e_bi, e_be, e_fl, e_to, hit, lu, pend;
            e_stall = 5'b00000; e_bi = 0; e_be = 0; e_fl = 0; e_to = 0; hit = 0;
            lu = is_load && wreg && ((r1_rd && r1_a == wd) || (r2_rd && r2_a == wd));
            if (rst) begin
                m_waiting[k] = 0; m_elapsed[k] = 0; m_pending[k] = 0;
                m_flush_due[k] = 0; m_tout[k] = 0;
            end else if (m_flush_due[k]) begin
                e_fl = 1;
                m_pending[k] = 0;
                m_flush_due[k] = freq;
            end else if (m_waiting[k]) begin
                pend = m_pending[k] || freq;
                if (done || m_elapsed[k] == max_stall(k)) begin
                    hit = !done;
                    m_waiting[k] = 0;
                    m_flush_due[k] = pend;
                    m_pending[k] = 0;
                end else begin
                    e_stall = 5'b00111; e_be = 1;
                    m_elapsed[k]++;
                    m_pending[k] = pend;
                end
            end else begin
                if (freq) begin
                    m_flush_due[k] = 1;
                end else if (sreq) begin
                    e_stall = 5'b00111; e_be = 1;
                    m_waiting[k] = 1; m_elapsed[k] = 1;
                end else if (lu) begin
                    e_stall = 5'b00011; e_bi = 1;
                end
            end
            e_to = !rst && (m_tout[k] || hit);
            if (hit) m_tout[k] = 1;

            check_val("stall",         k, 16'(o_stall[k]), 16'(e_stall));
            check_val("bubble_idex",   k, 16'(o_bi[k]),    16'(e_bi));
            check_val("bubble_exmem",  k, 16'(o_be[k]),    16'(e_be));
            check_val("flush",         k, 16'(o_fl[k]),    16'(e_fl));
            check_val("stall_timeout", k, 16'(o_to[k]),    16'(e_to));
`ifdef PIPE_CTRL_PERF_EN
            if (rst) begin
                check_val("perf_stall_cyc", k, o_pst[k], 16'd0);
                check_val("perf_flush_cnt", k, o_pfl[k], 16'd0);
                m_pstall[k] = 0; m_pflush[k] = 0;
            end else begin
                check_val("perf_stall_cyc", k, o_pst[k], 16'(m_pstall[k]));
                check_val("perf_flush_cnt", k, o_pfl[k], 16'(m_pflush[k]));
                if (e_stall != 0 && m_pstall[k] < 65535) m_pstall[k]++;
                if (e_fl && m_pflush[k] < 65535) m_pflush[k]++;
            end
`endif
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        set_idle();
        rst = 1;
        @(posedge clk);
        #1;
        tick(); tick();
        rst = 0;
        tick();

        // Load-use on read port 2, then the two non-hazard variants.
        is_load = 1; wreg = 1; wd = 4'h3; r2_rd = 1; r2_a = 4'h3;
        tick();
        set_idle(); tick();
        is_load = 1; wreg = 1; wd = 4'h3; r2_rd = 0; r2_a = 4'h3; tick();
        is_load = 0; r2_rd = 1; tick();
        // Address 0 hazard through read port 1.
        is_load = 1; wreg = 1; wd = 4'h0; r1_rd = 1; r1_a = 4'h0; r2_rd = 0; tick();
        set_idle(); tick();

        // Multi-cycle op finishing at cycle 5.
        rst = 1; tick(); rst = 0;
        sreq = 1; tick(); sreq = 0;
        for (int i = 1; i < 5; i++) tick();
        done = 1; tick(); done = 0;
        tick(); tick();

        // Flush requested mid-wait, acted on after ex_done.
        rst = 1; tick(); rst = 0;
        sreq = 1; tick(); sreq = 0;
        tick();
        freq = 1; tick(); freq = 0;
        tick();
        done = 1; tick(); done = 0;
        tick(); tick();

        // Watchdog expiry; timeout must stay set until reset.
        rst = 1; tick(); rst = 0;
        sreq = 1; tick(); sreq = 0;
        for (int i = 0; i < 10; i++) tick();
        sreq = 1; tick(); sreq = 0;
        tick();

        // Back-to-back branches and reset in the middle of a wait.
        freq = 1; tick(); tick(); freq = 0; tick();
        sreq = 1; tick(); sreq = 0; tick(); tick();
        rst = 1; tick(); rst = 0; tick(); tick();

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            set_random();
            tick();
        end
        rst = 0;
        set_idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
